// File: rtl/serializer_8bit.sv
// Parallel-in/serial-out stage for the 8-bit holding register, with a ready/load handshake,
// a frame strobe and an end-of-frame pulse. Define PARITY_EN to append an even-parity bit.
module serializer_8bit #(
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] d,
    input  logic       load,
    output logic       ready,
    output logic       sout,
    output logic       frame,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DONE_S = 2'd2
    } state_t;

`ifdef PARITY_EN
    localparam logic [3:0] LAST_CNT = 4'd8;
`else
    localparam logic [3:0] LAST_CNT = 4'd7;
`endif

    function automatic logic first_bit(input logic [7:0] w);
        return (MSB_FIRST == 1'b1) ? w[7] : w[0];
    endfunction

    // Bit that becomes the line bit once the word has been shifted one place.
    function automatic logic following_bit(input logic [7:0] w);
        return (MSB_FIRST == 1'b1) ? w[6] : w[1];
    endfunction

    function automatic logic [7:0] shift_word(input logic [7:0] w);
        return (MSB_FIRST == 1'b1) ? {w[6:0], 1'b0} : {1'b0, w[7:1]};
    endfunction

`ifdef PARITY_EN
    function automatic logic even_parity(input logic [7:0] w);
        return ^w;
    endfunction
`endif

    state_t     state_r, state_s;
    logic [3:0] cnt_r, cnt_s;
    logic [7:0] shreg_r, shreg_s;
    logic       ready_s, sout_s, frame_s, done_s;
`ifdef PARITY_EN
    logic       parity_r, parity_s;
`endif

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        shreg_s  = shreg_r;
        ready_s  = 1'b0;
        sout_s   = IDLE_LEVEL;
        frame_s  = 1'b0;
        done_s   = 1'b0;
`ifdef PARITY_EN
        parity_s = parity_r;
`endif
        case (state_r)
            IDLE: begin
                if (load) begin
                    state_s  = SHIFT;
                    shreg_s  = d;
                    cnt_s    = 4'd0;
                    sout_s   = first_bit(d);
                    frame_s  = 1'b1;
`ifdef PARITY_EN
                    parity_s = even_parity(d);
`endif
                end else begin
                    ready_s = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_r == LAST_CNT) begin
                    state_s = DONE_S;
                    cnt_s   = 4'd0;
                    done_s  = 1'b1;
                end
`ifdef PARITY_EN
                else if (cnt_r == 4'd7) begin
                    sout_s  = parity_r;
                    frame_s = 1'b1;
                    cnt_s   = cnt_r + 4'd1;
                end
`endif
                else begin
                    sout_s  = following_bit(shreg_r);
                    shreg_s = shift_word(shreg_r);
                    frame_s = 1'b1;
                    cnt_s   = cnt_r + 4'd1;
                end
            end
            DONE_S: begin
                state_s = IDLE;
                ready_s = 1'b1;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
                ready_s = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers; clr aborts any frame in progress.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            shreg_r  <= 8'h00;
            ready    <= 1'b1;
            sout     <= IDLE_LEVEL;
            frame    <= 1'b0;
            done     <= 1'b0;
`ifdef PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            shreg_r  <= shreg_s;
            ready    <= ready_s;
            sout     <= sout_s;
            frame    <= frame_s;
            done     <= done_s;
`ifdef PARITY_EN
            parity_r <= parity_s;
`endif
        end
    end

endmodule
